fsquare_pipe: RTL and testbench
===============================

Name: fsquare_pipe

Overview:
- Pipelined single-precision floating-point squarer: y = x*x, IEEE-754 binary32 in and out.
- Inverse companion of the combinational fsqrt. It feeds sqrt/square round-trip checks and the FPU's x^2 fast path.
- Sits beside the other FPU units behind a valid/ready handshake. Fixed 3-cycle latency with full backpressure.

Parameters:
- none. Widths are fixed at binary32.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- x  input  32  operand {sign, exp[7:0], frac[22:0]}
- in_valid  input  1  x is valid this cycle
- in_ready  output  1  unit accepts x this cycle
- y  output  32  result x*x
- out_valid  output  1  y is valid
- out_ready  input  1  consumer accepts y

Behaviour:
- Reset: while rst is high, all stage-valid bits clear and all data registers clear.
  - out_valid=0, y=32'h0, in_ready=1 after the reset edge.
  - Reset mid-operation discards every in-flight operand; nothing is emitted afterwards.
- Pipeline:
  - S1 registers the operand and decodes exp/frac with the hidden bit.
  - S2 registers the 48-bit product m*m and the provisional exponent 2e-127, computed in a 10-bit signed width.
  - S3 normalises, rounds, handles specials and drives y.
- Handshake and latency:
  - Accept occurs when in_valid && in_ready.
  - Result appears with out_valid=1 exactly 3 rising edges after accept when out_ready stays high.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, all stages hold. y and out_valid stay stable until accepted.
  - Bubbles are not compressed. Order is strictly preserved, with no loss or duplication.
- Throughput: one result per cycle with no stall.
- Arithmetic:
  - Output sign is always 0.
  - If product bit 47 is set, normalise right by 1 and increment the exponent.
  - Round to nearest, ties to even, on the 24-bit significand using the guard bit and the OR of the remaining bits as sticky.
  - A rounding carry-out renormalises the significand and increments the exponent again.
- Special cases, decided by input exponent:
  - exp==0 (zero/denormal, flushed): y=32'h00000000.
  - exp==255 with frac==0 (Inf): y=32'h7F800000.
  - exp==255 with frac!=0 (NaN): y=32'h7FC00000.
- Final exponent range:
  - Final exponent >=255: y=32'h7F800000 (overflow).
  - Final exponent <=0: y=32'h00000000 (underflow, flush; no denormal output).
- Accuracy: results are bit-exact to IEEE RNE for normal in-range results.

Optional Feature:
- Macro FSQUARE_FLAGS_EN.
- Defined: adds output port flags[2:0] = {overflow, underflow, invalid}.
  - flags is aligned with y and valid only when out_valid=1; it holds during a stall.
  - invalid is set for NaN input.
  - overflow is set when a finite input produces Inf.
  - underflow is set when a nonzero input flushes to 0.
  - Reset value is 3'b000.
- Undefined: no flags port and no flag registers. All other behaviour is identical.

Test Plan:
- x=32'h40000000 (2.0), out_ready=1 -> y=32'h40800000 (4.0), out_valid high exactly 3 edges after accept, for one cycle.
- Back-to-back 32'h3FC00000 (1.5), 32'hC0400000 (-3.0), 32'h3F800001 (1+2^-23) -> in order y=32'h40100000, 32'h41100000, 32'h3F800002 on consecutive cycles.
- x=32'h3FFFFFFF -> y=32'h407FFFFE; x=32'h7F000000 -> y=32'h7F800000 (flags=3'b100 with FSQUARE_FLAGS_EN); x=32'h1F800000 -> y=32'h00000000 (flags=3'b010).
- x=32'h7FC12345 -> y=32'h7FC00000 (flags=3'b001); x=32'hFF800000 -> y=32'h7F800000 (flags=3'b000); x=32'h00400000 -> y=32'h00000000 (flags=3'b000).
- Stream 6 operands 1.0..6.0 with out_ready low for 5 cycles after the first out_valid -> in_ready low while stalled, y held stable, outputs 1,4,9,16,25,36 exactly once each, in order.
- Assert rst with 2 operands in flight -> out_valid=0 and y=0 immediately; with rst released and no new input, out_valid stays 0 for 5 cycles.

Source files
------------

// File: rtl/fsquare_pipe.sv
// Three-stage binary32 squarer y = x*x with valid/ready backpressure.
// Define FSQUARE_FLAGS_EN to add the {overflow, underflow, invalid} flags output.
module fsquare_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] y,
   output logic        out_valid,
   input  logic        out_ready
`ifdef FSQUARE_FLAGS_EN
   ,
   output logic [2:0]  flags
`endif
);

   localparam logic [1:0] CLS_NORM = 2'd0;
   localparam logic [1:0] CLS_ZERO = 2'd1;
   localparam logic [1:0] CLS_INF  = 2'd2;
   localparam logic [1:0] CLS_NAN  = 2'd3;

   logic               advance_s;
   logic [1:0]         in_cls_s;
   logic               unused_sign_s;

   logic               v1_r;
   logic [1:0]         cls1_r;
   logic [7:0]         exp1_r;
   logic [23:0]        mant1_r;

   logic               v2_r;
   logic [1:0]         cls2_r;
   logic [47:0]        prod2_r;
   logic signed [9:0]  exp2_r;

   logic               v3_r;
   logic [31:0]        y_r;

   logic signed [9:0]  norm_exp_s;
   logic signed [9:0]  fin_exp_s;
   logic [23:0]        sig_s;
   logic               guard_s;
   logic               sticky_s;
   logic               round_up_s;
   logic [24:0]        rnd_sum_s;
   logic [23:0]        fin_sig_s;
   logic               ovf_s;
   logic               unf_s;
   logic [31:0]        y_nxt_s;

   // The sign never reaches the result; squares are non-negative.
   assign unused_sign_s = x[31];

   // Global stall: every stage holds while the output is blocked.
   assign advance_s = !(v3_r && !out_ready);
   assign in_ready  = advance_s;
   assign out_valid = v3_r;
   assign y         = y_r;

   // Operand classification from the input exponent and fraction.
   always_comb begin
      in_cls_s = CLS_NORM;
      if (x[30:23] == 8'd0) begin
         in_cls_s = CLS_ZERO;
      end else if (x[30:23] == 8'hFF) begin
         in_cls_s = (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
      end else begin
         in_cls_s = CLS_NORM;
      end
   end

   // Stage 1: capture operand with hidden bit restored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_r    <= 1'b0;
         cls1_r  <= 2'd0;
         exp1_r  <= 8'd0;
         mant1_r <= 24'd0;
      end else if (advance_s) begin
         v1_r    <= in_valid;
         cls1_r  <= in_cls_s;
         exp1_r  <= x[30:23];
         mant1_r <= {(x[30:23] != 8'd0), x[22:0]};
      end
   end

   // Stage 2: full significand product and provisional exponent 2e-127.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_r    <= 1'b0;
         cls2_r  <= 2'd0;
         prod2_r <= 48'd0;
         exp2_r  <= 10'sd0;
      end else if (advance_s) begin
         v2_r    <= v1_r;
         cls2_r  <= cls1_r;
         prod2_r <= {24'd0, mant1_r} * {24'd0, mant1_r};
         exp2_r  <= $signed({1'b0, exp1_r, 1'b0}) - 10'sd127;
      end
   end

   // Stage 3 datapath: normalise, round to nearest even, range and special handling.
   always_comb begin
      norm_exp_s = exp2_r;
      sig_s      = prod2_r[46:23];
      guard_s    = prod2_r[22];
      sticky_s   = |prod2_r[21:0];
      if (prod2_r[47]) begin
         norm_exp_s = exp2_r + 10'sd1;
         sig_s      = prod2_r[47:24];
         guard_s    = prod2_r[23];
         sticky_s   = |prod2_r[22:0];
      end else begin
         norm_exp_s = exp2_r;
      end
      round_up_s = guard_s && (sticky_s || sig_s[0]);
      rnd_sum_s  = {1'b0, sig_s} + {24'd0, round_up_s};
      if (rnd_sum_s[24]) begin
         fin_sig_s = rnd_sum_s[24:1];
         fin_exp_s = norm_exp_s + 10'sd1;
      end else begin
         fin_sig_s = rnd_sum_s[23:0];
         fin_exp_s = norm_exp_s;
      end
      ovf_s = (cls2_r == CLS_NORM) && (fin_exp_s >= 10'sd255);
      unf_s = (cls2_r == CLS_NORM) && (fin_exp_s <= 10'sd0);
      case (cls2_r)
         CLS_ZERO: y_nxt_s = 32'h0000_0000;
         CLS_INF:  y_nxt_s = 32'h7F80_0000;
         CLS_NAN:  y_nxt_s = 32'h7FC0_0000;
         CLS_NORM: begin
            if (ovf_s) begin
               y_nxt_s = 32'h7F80_0000;
            end else if (unf_s) begin
               y_nxt_s = 32'h0000_0000;
            end else begin
               y_nxt_s = {1'b0, fin_exp_s[7:0], fin_sig_s[22:0]};
            end
         end
         default:  y_nxt_s = 32'h0000_0000;
      endcase
   end

   // Stage 3 register: drives the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3_r <= 1'b0;
         y_r  <= 32'h0000_0000;
      end else if (advance_s) begin
         v3_r <= v2_r;
         y_r  <= y_nxt_s;
      end
   end

`ifdef FSQUARE_FLAGS_EN
   logic [2:0] flags_r;
   logic [2:0] flags_nxt_s;

   // Exception flags for the result leaving stage 2.
   always_comb begin
      flags_nxt_s = {ovf_s, unf_s, (cls2_r == CLS_NAN)};
   end

   // Flags travel with y and hold during a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_r <= 3'b000;
      end else if (advance_s) begin
         flags_r <= flags_nxt_s;
      end
   end

   assign flags = flags_r;
`endif

endmodule

// File: tb/tb_fsquare_pipe.sv
// Directed self-checking bench for fsquare_pipe.
// Flag checks are compiled in when FSQUARE_FLAGS_EN is defined.
module tb_fsquare_pipe;

   logic        clk;
   logic        rst;
   logic [31:0] x;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] y;
   logic        out_valid;
   logic        out_ready;
`ifdef FSQUARE_FLAGS_EN
   logic [2:0]  flags;
`endif

   int checks;
   int errors;

   fsquare_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef FSQUARE_FLAGS_EN
      ,
      .flags     (flags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One operand in isolation: latency, result, flags and single-cycle pulse.
   task automatic run_single(input string tag, input logic [31:0] xi,
                             input logic [31:0] ye, input logic [2:0] fe);
      @(negedge clk);
      x = xi;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_y"}, y, ye);
`ifdef FSQUARE_FLAGS_EN
      chk({tag, "_flags"}, 32'(flags), 32'(fe));
`else
      if (fe == 3'b111) $display("unused flag expectation for %s", tag);
`endif
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
   endtask

   logic [31:0] ops [6];
   logic [31:0] sq  [6];

   initial begin
      int idx_in;
      int idx_out;
      int stall_left;
      bit first_seen;
      bit was_stalled;
      logic [31:0] held_y;

      checks = 0;
      errors = 0;
      x = 32'h0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", y, 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_single("sq2", 32'h4000_0000, 32'h4080_0000, 3'b000);

      // Back-to-back stream without stalls.
      @(negedge clk);
      x = 32'h3FC0_0000; in_valid = 1'b1;
      @(negedge clk);
      x = 32'hC040_0000;
      @(negedge clk);
      x = 32'h3F80_0001;
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_v0", 32'(out_valid), 32'd1);
      chk("b2b_y0", y, 32'h4010_0000);
      @(negedge clk);
      chk("b2b_v1", 32'(out_valid), 32'd1);
      chk("b2b_y1", y, 32'h4110_0000);
      @(negedge clk);
      chk("b2b_v2", 32'(out_valid), 32'd1);
      chk("b2b_y2", y, 32'h3F80_0002);
      @(negedge clk);
      chk("b2b_end", 32'(out_valid), 32'd0);

      run_single("round", 32'h3FFF_FFFF, 32'h407F_FFFE, 3'b000);
      run_single("ovf",   32'h7F00_0000, 32'h7F80_0000, 3'b100);
      run_single("unf",   32'h1F80_0000, 32'h0000_0000, 3'b010);
      run_single("nan",   32'h7FC1_2345, 32'h7FC0_0000, 3'b001);
      run_single("ninf",  32'hFF80_0000, 32'h7F80_0000, 3'b000);
      run_single("denorm",32'h0040_0000, 32'h0000_0000, 3'b000);

      // Stream 1..6 with a 5-cycle stall on the first result.
      ops[0] = 32'h3F80_0000; sq[0] = 32'h3F80_0000;
      ops[1] = 32'h4000_0000; sq[1] = 32'h4080_0000;
      ops[2] = 32'h4040_0000; sq[2] = 32'h4110_0000;
      ops[3] = 32'h4080_0000; sq[3] = 32'h4180_0000;
      ops[4] = 32'h40A0_0000; sq[4] = 32'h41C8_0000;
      ops[5] = 32'h40C0_0000; sq[5] = 32'h4210_0000;
      idx_in = 0; idx_out = 0; stall_left = 0;
      first_seen = 1'b0; was_stalled = 1'b0; held_y = 32'h0;
      for (int cyc = 0; cyc < 60 && idx_out < 6; cyc++) begin
         @(negedge clk);
         if (out_valid && !first_seen) begin
            first_seen = 1'b1;
            stall_left = 5;
         end
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         #1;
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (was_stalled) chk("stall_y_hold", y, held_y);
            held_y = y;
            was_stalled = 1'b1;
         end else begin
            was_stalled = 1'b0;
         end
         if (out_valid && out_ready) begin
            chk($sformatf("stream_y%0d", idx_out), y, sq[idx_out]);
            idx_out++;
         end
         if (idx_in < 6) begin
            x = ops[idx_in];
            in_valid = 1'b1;
            if (in_ready) idx_in++;
         end else begin
            in_valid = 1'b0;
         end
      end
      chk("stream_count", 32'(idx_out), 32'd6);
      out_ready = 1'b1;
      in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stream_no_dup", 32'(out_valid), 32'd0);
      end

      // Reset with two operands in flight.
      @(negedge clk);
      x = 32'h4000_0000; in_valid = 1'b1;
      @(negedge clk);
      x = 32'h4040_0000;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_y", y, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_quiet", 32'(out_valid), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
